// File: rtl/rle_loader_pkg.sv
// rle_loader_pkg: shared FSM encoding, header field widths and packet-size limits for rle_stream_loader
package rle_loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_DECODE,
        S_ROWEND,
        S_CHECK,
        S_DONE
    } state_t;
    localparam int P_W = 6;
    localparam int CNT_W = 16;
    localparam int STRIDE_W = 16;
    localparam int HDR_FIXED = 2;
    localparam int MIN_PACKET_SIZE = 2;
endpackage

// File: rtl/rle_packet_extractor.sv
// rle_packet_extractor: picks packet j (MSB-first) out of a bus word for packet size p
// Ports: word_i held payload word, p_i packet size, j_i packet index;
//        val_o run value bit, len_o run length, last_o packet j is the last whole packet in the word
module rle_packet_extractor
    import rle_loader_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] word_i,
    input  logic [P_W-1:0]       p_i,
    input  logic [P_W-1:0]       j_i,
    output logic                 val_o,
    output logic [BUS_WIDTH-2:0] len_o,
    output logic                 last_o
);
    logic [31:0]          pos;
    logic [BUS_WIDTH-1:0] sh;
    always_comb begin
        pos    = 32'(j_i) * 32'(p_i);
        sh     = word_i << pos;
        val_o  = sh[BUS_WIDTH-1];
        len_o  = sh[BUS_WIDTH-2:0] >> (32'(BUS_WIDTH) - 32'(p_i));
        // another whole packet fits only if packet j+1 ends inside the word
        last_o = (pos + 2 * 32'(p_i)) > 32'(BUS_WIDTH);
    end
endmodule

// File: rtl/rle_stream_loader.sv
// rle_stream_loader: decodes a headered run-length bus stream into DATA_WIDTH-bit RAM writes across regions
// Ports: CLK/RST (sync, active-high); Loading_Enable rise starts a load; CPU_Bus/Bus_Valid/Bus_Ready word handshake;
//        RAM_WE/RAM_Address/RAM_Data registered write port; Done_Loading, Fmt_Err, Checksum_Err sticky status.
// Optional: define RLE_CHECKSUM_EN to XOR payload words and compare against one trailer word.
module rle_stream_loader
    import rle_loader_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGIONS = 3,
    parameter logic [NUM_REGIONS*ADDRESS_WIDTH-1:0] REGION_BASE = {13'd5007, 13'd2507, 13'd0},
    parameter logic [NUM_REGIONS*STRIDE_W-1:0] REGION_STRIDE = {16'd50, 16'd0, 16'd0}
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Loading_Enable,
    input  logic [BUS_WIDTH-1:0]     CPU_Bus,
    input  logic                     Bus_Valid,
    output logic                     Bus_Ready,
    output logic                     RAM_WE,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address,
    output logic [DATA_WIDTH-1:0]    RAM_Data,
    output logic                     Done_Loading,
    output logic                     Fmt_Err,
    output logic                     Checksum_Err
);
    localparam int RW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
`ifdef RLE_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif
    state_t                   state_q;
    logic [BUS_WIDTH-1:0]     word_q;
    logic [P_W-1:0]           p_q, j_q;
    logic [CNT_W-1:0]         e_q, col_q, row_q;
    logic [CNT_W-1:0]         rows_q [NUM_REGIONS];
    logic [RW-1:0]            region_q, nreg_d;
    logic [7:0]               hdr_q;
    logic [ADDRESS_WIDTH-1:0] addr_q, row_start_q, nbase_d, rnext_d;
    logic [ADDRESS_WIDTH-1:0] base_a [NUM_REGIONS];
    logic [ADDRESS_WIDTH-1:0] stride_a [NUM_REGIONS];
    logic [DATA_WIDTH-1:0]    elem_q, elem_d, mask_d;
    logic [31:0]              fill_q, run_len_q, cur_len_d, space_d, n_d, rem_d;
    logic                     run_val_q, le_q, cur_val_d, full_d, row_end_d, found_d, p_ok_d;
    logic                     pk_val, pk_last;
    logic [BUS_WIDTH-2:0]     pk_len;
    logic [NUM_REGIONS-1:0]   nz_d;
    int                       sfrom_d;
`ifdef RLE_CHECKSUM_EN
    logic [BUS_WIDTH-1:0]     sum_q;
`else
    assign Checksum_Err = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_reg
        assign base_a[g]   = REGION_BASE[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign stride_a[g] = ADDRESS_WIDTH'(REGION_STRIDE[g*STRIDE_W +: STRIDE_W]);
        // the last region's count is still on the bus during the final header cycle
        assign nz_d[g] = (g == NUM_REGIONS - 1 && state_q == S_HDR) ? |CPU_Bus[CNT_W-1:0] : |rows_q[g];
    end

    rle_packet_extractor #(.BUS_WIDTH(BUS_WIDTH)) u_ext (
        .word_i(word_q),
        .p_i   (p_q),
        .j_i   (j_q),
        .val_o (pk_val),
        .len_o (pk_len),
        .last_o(pk_last)
    );

    assign Bus_Ready    = state_q == S_HDR || state_q == S_FETCH || state_q == S_CHECK;
    assign Done_Loading = state_q == S_DONE;

    always_comb begin
        // a held run (from an element-spanning packet) takes priority over the next packet
        cur_len_d = run_len_q != 0 ? run_len_q : 32'(pk_len);
        cur_val_d = run_len_q != 0 ? run_val_q : pk_val;
        space_d   = 32'(DATA_WIDTH) - fill_q;
        full_d    = cur_len_d >= space_d;
        n_d       = full_d ? space_d : cur_len_d;
        rem_d     = cur_len_d - n_d;
        mask_d    = ({DATA_WIDTH{1'b1}} >> fill_q) & ~({DATA_WIDTH{1'b1}} >> (fill_q + n_d));
        elem_d    = elem_q | (cur_val_d ? mask_d : '0);
        row_end_d = full_d && (col_q + CNT_W'(1) == e_q);
        p_ok_d    = 32'(CPU_Bus[P_W-1:0]) >= MIN_PACKET_SIZE && 32'(CPU_Bus[P_W-1:0]) <= BUS_WIDTH;
        sfrom_d   = state_q == S_HDR ? 0 : 32'(region_q) + 1;
        found_d   = 1'b0;
        nreg_d    = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (k >= sfrom_d && nz_d[k]) begin
                found_d = 1'b1;
                nreg_d  = RW'(k);
            end
        end
        nbase_d = base_a[nreg_d];
        rnext_d = stride_a[region_q] == '0 ? addr_q : row_start_q + stride_a[region_q];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            le_q        <= 1'b0;
            RAM_WE      <= 1'b0;
            RAM_Address <= '0;
            RAM_Data    <= '0;
            Fmt_Err     <= 1'b0;
            word_q      <= '0;
            p_q         <= '0;
            j_q         <= '0;
            e_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            region_q    <= '0;
            hdr_q       <= '0;
            addr_q      <= '0;
            row_start_q <= '0;
            elem_q      <= '0;
            fill_q      <= '0;
            run_len_q   <= '0;
            run_val_q   <= 1'b0;
            for (int k = 0; k < NUM_REGIONS; k++) rows_q[k] <= '0;
`ifdef RLE_CHECKSUM_EN
            sum_q        <= '0;
            Checksum_Err <= 1'b0;
`endif
        end else begin
            le_q   <= Loading_Enable;
            RAM_WE <= 1'b0;
            case (state_q)
                S_IDLE: if (Loading_Enable && !le_q) begin
                    state_q   <= S_HDR;
                    hdr_q     <= '0;
                    Fmt_Err   <= 1'b0;
                    elem_q    <= '0;
                    fill_q    <= '0;
                    run_len_q <= '0;
                    col_q     <= '0;
                    j_q       <= '0;
`ifdef RLE_CHECKSUM_EN
                    sum_q        <= '0;
                    Checksum_Err <= 1'b0;
`endif
                end
                S_HDR: if (Bus_Valid) begin
                    hdr_q <= hdr_q + 8'd1;
                    for (int k = 0; k < NUM_REGIONS; k++)
                        if (32'(hdr_q) == k + HDR_FIXED) rows_q[k] <= CPU_Bus[CNT_W-1:0];
                    if (hdr_q == 8'd0) begin
                        p_q <= CPU_Bus[P_W-1:0];
                        if (!p_ok_d) begin
                            Fmt_Err <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (hdr_q == 8'd1) begin
                        e_q <= CPU_Bus[CNT_W-1:0];
                        if (CPU_Bus[CNT_W-1:0] == '0) begin
                            Fmt_Err <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (hdr_q == 8'(NUM_REGIONS + 1)) begin
                        region_q    <= nreg_d;
                        row_q       <= '0;
                        addr_q      <= nbase_d;
                        row_start_q <= nbase_d;
                        state_q     <= found_d ? S_FETCH : S_TAIL;
                    end
                end
                S_FETCH: if (Bus_Valid) begin
                    word_q  <= CPU_Bus;
                    j_q     <= '0;
                    state_q <= S_DECODE;
`ifdef RLE_CHECKSUM_EN
                    sum_q <= sum_q ^ CPU_Bus;
`endif
                end
                S_DECODE: begin
                    run_val_q <= cur_val_d;
                    run_len_q <= row_end_d ? 32'd0 : rem_d;
                    if (full_d) begin
                        RAM_WE      <= 1'b1;
                        RAM_Address <= addr_q;
                        RAM_Data    <= elem_d;
                        addr_q      <= addr_q + ADDRESS_WIDTH'(1);
                        elem_q      <= '0;
                        fill_q      <= '0;
                        col_q       <= col_q + CNT_W'(1);
                    end else begin
                        elem_q <= elem_d;
                        fill_q <= fill_q + n_d;
                    end
                    // leftover run bits at row end are discarded along with the rest of the word
                    if (row_end_d) begin
                        if (rem_d != 0) Fmt_Err <= 1'b1;
                        col_q   <= '0;
                        state_q <= S_ROWEND;
                    end else if (rem_d == 0) begin
                        j_q     <= pk_last ? '0 : j_q + P_W'(1);
                        state_q <= pk_last ? S_FETCH : S_DECODE;
                    end
                end
                S_ROWEND: begin
                    j_q <= '0;
                    if (row_q + CNT_W'(1) < rows_q[region_q]) begin
                        row_q       <= row_q + CNT_W'(1);
                        addr_q      <= rnext_d;
                        row_start_q <= rnext_d;
                    end else if (found_d) begin
                        region_q    <= nreg_d;
                        row_q       <= '0;
                        addr_q      <= nbase_d;
                        row_start_q <= nbase_d;
                    end
                    state_q <= (row_q + CNT_W'(1) < rows_q[region_q] || found_d) ? S_FETCH : S_TAIL;
                end
`ifdef RLE_CHECKSUM_EN
                S_CHECK: if (Bus_Valid) begin
                    Checksum_Err <= CPU_Bus != sum_q;
                    state_q      <= S_DONE;
                end
`endif
                S_DONE: if (!Loading_Enable) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
